rgb_preset_sequencer: RTL and testbench
=======================================

Name: rgb_preset_sequencer

Overview:
Controller that sits between the three encoder values and the three PWM level inputs of the RGB mixer. In manual mode it passes the encoder levels straight through. In auto mode it cycles through a small preset table of RGB colours, ramping each channel linearly toward the next preset, then holding it. Presets are written through a simple register-write port.

Parameters:
WIDTH, 8, bits per colour channel (matches PWM/encoder width)
NUM_PRESETS, 4, preset table depth (power of 2, >=2)
STEP_DIV, 16, clk cycles per fade/hold step (tick period, >=2)
HOLD_STEPS, 64, ticks a reached preset is held before advancing (>=1)

Ports:
clk  in  1  block clock (divided mixer clock)
reset  in  1  synchronous, active-high reset
manual_level  in  3*WIDTH  encoder levels; channel i at [WIDTH*i +: WIDTH]
auto_en  in  1  1 = run preset sequence, 0 = manual pass-through
wr_en  in  1  preset write strobe
wr_addr  in  $clog2(NUM_PRESETS)  preset index to write
wr_data  in  3*WIDTH  preset colour, same packing as manual_level
level_out  out  3*WIDTH  levels to the PWMs, same packing
preset_idx  out  $clog2(NUM_PRESETS)  current target preset
fading  out  1  high while in FADE
wrap  out  1  one-cycle pulse when preset_idx wraps to 0

Behaviour:
- Reset (takes priority over everything): level_out=0, preset_idx=0, fading=0, wrap=0, state=MANUAL, tick and hold counters=0, all preset entries=0.
- All outputs registered; level_out, preset_idx, fading, wrap change only on posedge clk.
- States: MANUAL, FADE, HOLD.
- MANUAL: level_out <= manual_level every cycle (1-cycle latency). Tick/hold counters held at 0. If auto_en=1: next state FADE, preset_idx <= 0, tick counter <= 0.
- Tick: tick counter counts 0..STEP_DIV-1 and wraps in FADE and HOLD; tick asserted on the cycle counter==STEP_DIV-1. The first tick occurs STEP_DIV cycles after entering FADE from MANUAL.
- FADE: target = preset[preset_idx], read combinationally from the table. On tick, each channel independently moves by +1 if below target, -1 if above, unchanged if equal. No overshoot, no wrap-around (0 and 2^WIDTH-1 are never crossed). Leave FADE when, on a tick, all three updated channels equal target. Next state HOLD, hold counter <= 0. If level already equals target on entry, transition happens on the first tick with no level change.
- HOLD: level_out constant. On each tick the hold counter increments. On the tick where hold counter==HOLD_STEPS-1: preset_idx <= preset_idx+1 mod NUM_PRESETS, next state FADE. The tick counter continues free-running.
- wrap=1 for exactly the cycle following the HOLD->FADE transition that moves preset_idx from NUM_PRESETS-1 to 0. Otherwise 0.
- fading = (state==FADE), registered with state.
- auto_en=0 in FADE or HOLD: next state MANUAL and level_out <= manual_level on that same edge (abrupt jump, no fade-out). preset_idx is retained until the next auto entry.
- Preset writes: wr_en writes wr_data to preset[wr_addr] on the edge in any state. The new value is visible as target from the next cycle. A write to the current target during FADE redirects the ramp. A write during HOLD does not affect level_out until that index is targeted again.
- Simultaneous auto_en deassert and tick: MANUAL wins; no level step and no index advance.

Test Plan:
(Parameters: WIDTH=8, NUM_PRESETS=4, STEP_DIV=4, HOLD_STEPS=2.)
1. Reset: assert reset 2 cycles with random inputs -> level_out=0, preset_idx=0, fading=0, wrap=0. Then manual_level=0x302010 -> level_out=0x302010 one cycle later.
2. Up-fade: preset0=0x000003, manual 0, raise auto_en.
   - fading=1 next cycle.
   - Channel 0 steps 1,2,3 at 4-cycle intervals; channels 1 and 2 stay 0.
   - fading drops after the third step.
   - HOLD lasts 8 cycles, then preset_idx=1 and fading=1.
3. Mixed directions: level 0x050005 and preset1=0x020307.
   - Channel 0 goes 5->6->7, channel 1 goes 0->3, channel 2 goes 5->2.
   - HOLD is entered on the third tick, with level_out=0x020307.
4. Wrap: run through presets 0..3 -> after preset3 hold, preset_idx=0 and wrap=1 for exactly one cycle. wrap=0 at every other index change.
5. Abort: deassert auto_en mid-fade with manual_level=0xAABBCC -> next edge level_out=0xAABBCC, fading=0, state MANUAL. Deassert coinciding with a tick -> no extra step.
6. Live write: during a FADE toward preset2=0x000010, write preset2=0x000002 while channel 0 is at 5 -> channel 0 ramps down 4,3,2, then HOLD.

Source files
------------

// File: rtl/rgb_preset_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_preset_sequencer
//
// Sits between the three encoder values and the three PWM level inputs of the
// RGB mixer. In manual mode the encoder levels pass straight through with one
// cycle of latency. In auto mode the block walks a small table of preset RGB
// colours: it ramps every channel linearly (one LSB per tick) toward the
// current preset, holds the colour for HOLD_STEPS ticks, then moves on to the
// next preset, wrapping back to preset 0 after the last one.
//
// Ports
//   clk           block clock (divided mixer clock)
//   reset         synchronous, active-high reset
//   manual_level  encoder levels, channel i at [WIDTH*i +: WIDTH]
//   auto_en       1 = run preset sequence, 0 = manual pass-through
//   wr_en         preset write strobe
//   wr_addr       preset index to write
//   wr_data       preset colour, same packing as manual_level
//   level_out     levels to the PWMs, same packing
//   preset_idx    preset currently being faded toward / held
//   fading        high while ramping toward a preset
//   wrap          one-cycle pulse after preset_idx wraps back to 0
//   state_dbg     current sequencer state (0 = MANUAL, 1 = FADE, 2 = HOLD)
//
// Write port semantics: there is no back-pressure. Every cycle with wr_en=1
// stores wr_data into preset[wr_addr] on that clock edge, in any state. The
// stored value is seen as the fade target from the following cycle on, so a
// write to the preset currently being faded toward redirects the ramp, while
// a write to any other entry only matters once that entry is targeted.
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module rgb_preset_sequencer #(
  parameter int WIDTH       = 8,
  parameter int NUM_PRESETS = 4,
  parameter int STEP_DIV    = 16,
  parameter int HOLD_STEPS  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3*WIDTH-1:0]             manual_level,
  input  logic                           auto_en,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_PRESETS)-1:0] wr_addr,
  input  logic [3*WIDTH-1:0]             wr_data,
  output logic [3*WIDTH-1:0]             level_out,
  output logic [$clog2(NUM_PRESETS)-1:0] preset_idx,
  output logic                           fading,
  output logic                           wrap,
  output logic [1:0]                     state_dbg
);

  localparam int AW = $clog2(NUM_PRESETS);
  localparam int TW = $clog2(STEP_DIV);
  // HOLD_STEPS may be 1, where $clog2 would give a zero-width counter.
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_PRESETS - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_FADE   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state_q;
  logic [3*WIDTH-1:0]   level_q;
  logic [AW-1:0]        idx_q;
  logic                 fading_q;
  logic                 wrap_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [HW-1:0]        hold_cnt_q;
  logic [3*WIDTH-1:0]   preset_q [NUM_PRESETS];

  // -------------------------------------------------------------------------
  // Next-value helpers
  // -------------------------------------------------------------------------
  logic [3*WIDTH-1:0]   target;
  logic                 tick;
  logic [TW-1:0]        tick_cnt_d;
  logic [3*WIDTH-1:0]   fade_level_d;
  logic                 fade_done;
  logic [AW-1:0]        idx_d;

  // Move one LSB toward the target. Because the step only happens when the
  // values differ, the result can never overshoot or wrap past 0 / max.
  function automatic logic [WIDTH-1:0] step_toward(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] tgt
  );
    logic [WIDTH-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 1'b1;
    end else if (cur > tgt) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    target       = preset_q[idx_q];
    tick         = (tick_cnt_q == TICK_LAST);
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    fade_level_d = level_q;
    for (int ch = 0; ch < 3; ch++) begin
      fade_level_d[ch*WIDTH +: WIDTH] =
        step_toward(level_q[ch*WIDTH +: WIDTH], target[ch*WIDTH +: WIDTH]);
    end
    // Judged on the post-step value so that the last step and the move into
    // HOLD happen on the same tick.
    fade_done = (fade_level_d == target);
    idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs and the preset table
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_MANUAL;
      level_q    <= '0;
      idx_q      <= '0;
      fading_q   <= 1'b0;
      wrap_q     <= 1'b0;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      for (int p = 0; p < NUM_PRESETS; p++) begin
        preset_q[p] <= '0;
      end
    end else begin
      if (wr_en) begin
        preset_q[wr_addr] <= wr_data;
      end

      wrap_q <= 1'b0;

      unique case (state_q)
        ST_MANUAL: begin
          level_q    <= manual_level;
          tick_cnt_q <= '0;
          hold_cnt_q <= '0;
          if (auto_en) begin
            state_q  <= ST_FADE;
            fading_q <= 1'b1;
            idx_q    <= '0;
          end
        end

        ST_FADE: begin
          if (!auto_en) begin
            // Abrupt return to the encoder levels; a coincident tick is
            // ignored. preset_idx is kept for visibility until re-entry.
            state_q    <= ST_MANUAL;
            fading_q   <= 1'b0;
            level_q    <= manual_level;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
          end else begin
            tick_cnt_q <= tick_cnt_d;
            if (tick) begin
              level_q <= fade_level_d;
              if (fade_done) begin
                state_q    <= ST_HOLD;
                fading_q   <= 1'b0;
                hold_cnt_q <= '0;
              end
            end
          end
        end

        ST_HOLD: begin
          if (!auto_en) begin
            state_q    <= ST_MANUAL;
            fading_q   <= 1'b0;
            level_q    <= manual_level;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
          end else begin
            // The tick counter keeps free-running so the next fade starts
            // in phase with the hold ticks.
            tick_cnt_q <= tick_cnt_d;
            if (tick) begin
              if (hold_cnt_q == HOLD_LAST) begin
                state_q    <= ST_FADE;
                fading_q   <= 1'b1;
                hold_cnt_q <= '0;
                idx_q      <= idx_d;
                wrap_q     <= (idx_q == IDX_LAST);
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
          end
        end

        default: begin
          state_q  <= ST_MANUAL;
          fading_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_out  = level_q;
  assign preset_idx = idx_q;
  assign fading     = fading_q;
  assign wrap       = wrap_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rgb_preset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgb_preset_sequencer
//
// Directed walk through reset, up-fade, mixed-direction fade, index wrap,
// abort and live preset rewrite, followed by a randomized run. Every clock
// edge is mirrored by a behavioural model built from the colour-sequencing
// rules (per-channel integer levels, a preset array, ticks derived from the
// number of cycles spent in auto mode) and all outputs are compared to it.
// ---------------------------------------------------------------------------
module tb_rgb_preset_sequencer;

  localparam int WIDTH       = 8;
  localparam int NUM_PRESETS = 4;
  localparam int STEP_DIV    = 4;
  localparam int HOLD_STEPS  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] manual_level;
  logic        auto_en;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic [23:0] level_out;
  logic [1:0]  preset_idx;
  logic        fading;
  logic        wrap;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  rgb_preset_sequencer #(
    .WIDTH       (WIDTH),
    .NUM_PRESETS (NUM_PRESETS),
    .STEP_DIV    (STEP_DIV),
    .HOLD_STEPS  (HOLD_STEPS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .manual_level (manual_level),
    .auto_en      (auto_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .level_out    (level_out),
    .preset_idx   (preset_idx),
    .fading       (fading),
    .wrap         (wrap),
    .state_dbg    (state_dbg)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  int m_lvl [3];
  int m_pre [NUM_PRESETS][3];
  int m_idx;
  bit m_auto;        // running the preset sequence
  bit m_fading;      // ramping (as opposed to holding)
  bit m_wrap;
  int m_since;       // cycles spent in auto mode since entry
  int m_hold_ticks;  // ticks spent holding the current preset

  function automatic logic [23:0] model_level();
    return {8'(m_lvl[2]), 8'(m_lvl[1]), 8'(m_lvl[0])};
  endfunction

  // True when the coming clock edge is a tick in the model.
  function automatic bit model_tick_next();
    return m_auto && (m_since % STEP_DIV == STEP_DIV - 1);
  endfunction

  task automatic model_edge();
    bit tick;
    bit all_eq;
    int tgt;
    if (reset) begin
      for (int c = 0; c < 3; c++) m_lvl[c] = 0;
      for (int p = 0; p < NUM_PRESETS; p++)
        for (int c = 0; c < 3; c++) m_pre[p][c] = 0;
      m_idx = 0; m_auto = 0; m_fading = 0; m_wrap = 0;
      m_since = 0; m_hold_ticks = 0;
      return;
    end
    m_wrap = 0;
    if (!m_auto) begin
      for (int c = 0; c < 3; c++) m_lvl[c] = int'(manual_level[8*c +: 8]);
      if (auto_en) begin
        m_auto = 1; m_fading = 1; m_idx = 0; m_since = 0;
      end
    end else if (!auto_en) begin
      m_auto = 0; m_fading = 0;
      for (int c = 0; c < 3; c++) m_lvl[c] = int'(manual_level[8*c +: 8]);
    end else begin
      tick = (m_since % STEP_DIV == STEP_DIV - 1);
      m_since++;
      if (tick) begin
        if (m_fading) begin
          all_eq = 1;
          for (int c = 0; c < 3; c++) begin
            tgt = m_pre[m_idx][c];
            if (m_lvl[c] < tgt) m_lvl[c]++;
            else if (m_lvl[c] > tgt) m_lvl[c]--;
            if (m_lvl[c] != tgt) all_eq = 0;
          end
          if (all_eq) begin
            m_fading = 0; m_hold_ticks = 0;
          end
        end else begin
          m_hold_ticks++;
          if (m_hold_ticks == HOLD_STEPS) begin
            m_hold_ticks = 0;
            m_idx = (m_idx + 1) % NUM_PRESETS;
            m_fading = 1;
            m_wrap = (m_idx == 0);
          end
        end
      end
    end
    if (wr_en)
      for (int c = 0; c < 3; c++) m_pre[wr_addr][c] = int'(wr_data[8*c +: 8]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("level_out",  32'(level_out),  32'(model_level()));
    check("preset_idx", 32'(preset_idx), 32'(m_idx));
    check("fading",     32'(fading),     32'(m_fading));
    check("wrap",       32'(wrap),       32'(m_wrap));
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    cycle();
    wr_en   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0]  prev_idx;
    logic [23:0] prev_lvl;
    logic [23:0] ramp [3];
    bit          found;

    // 1. Reset with random inputs, then manual pass-through
    reset        = 1'b1;
    manual_level = 24'($urandom);
    auto_en      = 1'($urandom);
    wr_en        = 1'($urandom);
    wr_addr      = 2'($urandom);
    wr_data      = 24'($urandom);
    cycle();
    cycle();
    check("reset_level", 32'(level_out), 32'h0);
    check("reset_idx",   32'(preset_idx), 32'h0);
    check("reset_fading", 32'(fading), 32'h0);
    check("reset_wrap",  32'(wrap), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);

    reset        = 1'b0;
    auto_en      = 1'b0;
    wr_en        = 1'b0;
    manual_level = 24'h302010;
    cycle();
    check("manual_pass", 32'(level_out), 32'h302010);

    // 2. Up-fade on channel 0 toward preset0 = 0x000003
    do_write(2'd0, 24'h000003);
    manual_level = 24'h0;
    cycle();
    auto_en = 1'b1;
    cycle();
    check("fade_entry", 32'(fading), 32'h1);
    repeat (3) cycle();
    check("before_first_tick", 32'(level_out), 32'h0);
    cycle();
    check("up_step1", 32'(level_out), 32'h000001);
    repeat (4) cycle();
    check("up_step2", 32'(level_out), 32'h000002);
    repeat (4) cycle();
    check("up_step3", 32'(level_out), 32'h000003);
    check("up_hold_entry", 32'(fading), 32'h0);
    repeat (7) cycle();
    check("hold_still", 32'(preset_idx), 32'h0);
    cycle();
    check("hold_advance_idx", 32'(preset_idx), 32'h1);
    check("hold_advance_fade", 32'(fading), 32'h1);

    // 5a. Abort mid-fade
    manual_level = 24'hAABBCC;
    auto_en      = 1'b0;
    cycle();
    check("abort_level", 32'(level_out), 32'hAABBCC);
    check("abort_fading", 32'(fading), 32'h0);
    check("abort_state", 32'(state_dbg), 32'h0);
    check("abort_idx_kept", 32'(preset_idx), 32'h1);

    // 3. Equal-on-entry preset, then mixed-direction fade to 0x020307
    do_write(2'd0, 24'h050005);
    do_write(2'd1, 24'h020307);
    do_write(2'd2, 24'h020306);
    do_write(2'd3, 24'h020307);
    manual_level = 24'h050005;
    cycle();
    auto_en = 1'b1;
    cycle();
    check("reentry_idx", 32'(preset_idx), 32'h0);
    repeat (4) cycle();
    check("equal_entry_level", 32'(level_out), 32'h050005);
    check("equal_entry_hold", 32'(fading), 32'h0);
    repeat (8) cycle();
    check("mixed_idx", 32'(preset_idx), 32'h1);
    ramp[0] = 24'h040106;
    ramp[1] = 24'h030207;
    ramp[2] = 24'h020307;
    for (int s = 0; s < 3; s++) begin
      repeat (4) cycle();
      check($sformatf("mixed_step%0d", s + 1), 32'(level_out), 32'(ramp[s]));
    end
    check("mixed_hold", 32'(fading), 32'h0);

    // 4. Walk to the index wrap
    prev_idx = preset_idx;
    found    = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      cycle();
      if (preset_idx != prev_idx) begin
        check("wrap_at_change", 32'(wrap), 32'(preset_idx == 2'd0));
        if (preset_idx == 2'd0) found = 1;
        prev_idx = preset_idx;
      end
    end
    check("wrap_reached", 32'(found), 32'h1);
    cycle();
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // 5b. Deassert auto_en on a tick edge
    found = 0;
    for (int n = 0; n < 2 * STEP_DIV && !found; n++) begin
      if (model_tick_next()) found = 1;
      else cycle();
    end
    check("tick_aligned", 32'(found), 32'h1);
    auto_en      = 1'b0;
    manual_level = 24'h112233;
    cycle();
    check("tick_abort_level", 32'(level_out), 32'h112233);
    check("tick_abort_idx", 32'(preset_idx), 32'h0);
    check("tick_abort_fading", 32'(fading), 32'h0);

    // 6. Live rewrite of the current target during a fade
    do_write(2'd0, 24'h000005);
    do_write(2'd1, 24'h000005);
    do_write(2'd2, 24'h000010);
    manual_level = 24'h000005;
    cycle();
    auto_en = 1'b1;
    found   = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      cycle();
      if (preset_idx == 2'd2 && fading) found = 1;
    end
    check("live_reach_idx2", 32'(found), 32'h1);
    check("live_start_level", 32'(level_out), 32'h000005);
    do_write(2'd2, 24'h000002);
    for (int s = 4; s >= 2; s--) begin
      prev_lvl = level_out;
      found    = 0;
      for (int n = 0; n < 4 * STEP_DIV && !found; n++) begin
        cycle();
        if (level_out != prev_lvl) found = 1;
      end
      check("live_step_seen", 32'(found), 32'h1);
      check($sformatf("live_step_to_%0d", s), 32'(level_out), 32'(s));
    end
    check("live_hold", 32'(fading), 32'h0);

    // 7. Randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 31) == 0) auto_en = ~auto_en;
      manual_level = 24'($urandom);
      wr_en        = ($urandom_range(0, 7) == 0);
      wr_addr      = 2'($urandom_range(0, 3));
      wr_data      = {4'h0, 4'($urandom_range(0, 15)),
                      4'h0, 4'($urandom_range(0, 15)),
                      4'h0, 4'($urandom_range(0, 15))};
      cycle();
    end
    reset = 1'b0;
    wr_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
